// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one 1-bit full subtractor walks a WIDTH-bit difference LSB-first,
// one bit per clock, with the inter-bit borrow held in a flop.

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_a_q, sr_b_q;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q, b_msb_q;
  logic             fs_d, fs_bout;
  logic             last_bit;

  full_subtractor u_fs (
    .x    (sr_a_q[0]),
    .y    (sr_b_q[0]),
    .bin  (brw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last_bit = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_a_q  <= '0;
      sr_b_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      D       <= '0;
      Bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_a_q  <= a;
            sr_b_q  <= b;
            brw_q   <= Bin;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            D       <= '0;
            Bout    <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          sr_a_q <= sr_a_q >> 1;
          sr_b_q <= sr_b_q >> 1;
          D      <= {fs_d, D[WIDTH-1:1]};
          brw_q  <= fs_bout;
          // Counter parks at the last index so it never exceeds WIDTH-1.
          if (!last_bit) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            Bout <= fs_bout;
            ovf  <= (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: a cycle-level reference model compared every
// negedge, plus directed literal expectations.

module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, ovf;
  logic [W-1:0] d;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .Bin   (bin),
    .busy  (busy),
    .done  (done),
    .D     (d),
    .Bout  (bout),
    .ovf   (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Returns {ovf, bout, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic bi);
    int ux, uy, sx, sy, ib, u, s;
    logic [W+1:0] r;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    ib = bi;
    u  = ux - uy - ib;
    s  = sx - sy - ib;
    r[W-1:0] = u[W-1:0];
    r[W]     = (u < 0);
    r[W+1]   = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    return r;
  endfunction

  // Model: phase 0 idle, 1 computing (counts down W edges), 2 done.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [W-1:0] m_d     = '0;
  logic         m_bout  = 1'b0;
  logic         m_ovf   = 1'b0;
  logic [W+1:0] m_pend  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_d     <= '0;
      m_bout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          m_left  <= W;
          m_pend  <= ref_sub(a, b, bin);
          m_d     <= '0;
          m_bout  <= 1'b0;
          m_ovf   <= 1'b0;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2;
            m_d     <= m_pend[W-1:0];
            m_bout  <= m_pend[W];
            m_ovf   <= m_pend[W+1];
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_phase == 2));
    if (m_phase != 1) begin
      chk("D", 32'(d), 32'(m_d));
      chk("Bout", 32'(bout), 32'(m_bout));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  // Leaves the bench at the first negedge after the accepting edge.
  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    bin   = bi;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic bi, input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    accept(x, y, bi);
    wait_done(n);
    chk({tag, "_latency"}, 32'(n), 32'(W + 1));
    chk({tag, "_D"}, 32'(d), 32'(ed));
    chk({tag, "_Bout"}, 32'(bout), 32'(eb));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
  endtask

  initial begin
    int           n, ndone;
    logic [W-1:0] x, y;
    logic         bi;
    logic [W+1:0] r;

    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #1 rst = 1'b1;
    #11;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_D", 32'(d), 32'd0);
    #1 rst = 1'b0;

    run_op("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("sub_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("sub_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("sub_eq", 8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);

    // Start while busy is ignored; start right after DONE is accepted.
    ndone = 0;
    accept(8'h0B, 8'h04, 1'b0);
    ndone += int'(done);
    repeat (2) begin @(negedge clk); ndone += int'(done); end
    start = 1'b1; a = 8'hFF; b = 8'h01; bin = 1'b1;
    @(negedge clk); ndone += int'(done);
    start = 1'b0;
    repeat (4) begin @(negedge clk); ndone += int'(done); end
    start = 1'b1; a = 8'hEE; b = 8'h11; bin = 1'b0;
    @(negedge clk); ndone += int'(done);
    start = 1'b0;
    chk("busy_ign_done", 32'(done), 32'd1);
    chk("busy_ign_D", 32'(d), 32'h07);
    @(negedge clk); ndone += int'(done);
    start = 1'b1; a = 8'h20; b = 8'h07; bin = 1'b0;
    @(negedge clk); ndone += int'(done);
    start = 1'b0;
    chk("busy_ign_pulses", 32'(ndone), 32'd1);
    chk("after_done_accept", 32'(busy), 32'd1);
    wait_done(n);
    chk("after_done_latency", 32'(n), 32'(W + 1));
    chk("after_done_D", 32'(d), 32'h19);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN aborts without a done pulse.
    accept(8'hFF, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_D", 32'(d), 32'd0);
    chk("abort_Bout", 32'(bout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    #1 rst = 1'b0;
    ndone = 0;
    repeat (12) begin @(negedge clk); ndone += int'(done); end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op("sub_a5_5a", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      x  = W'($urandom);
      y  = (i % 16 == 0) ? x : W'($urandom);
      bi = 1'($urandom);
      r  = ref_sub(x, y, bi);
      run_op("rand", x, y, bi, r[W-1:0], r[W], r[W+1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
